// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub: valid/ready on the operand side and on the result side.
interface pipe_addsub_if #(
  parameter int WIDTH = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor: carry chain cut into SEG-bit segments, one register stage each,
// with a single global advance enable so the whole pipe stalls as one under backpressure.
module pipe_addsub #(
  parameter int WIDTH = 11,
  parameter int SEG   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_addsub_if.slave bus
);
  localparam int NSTG = (WIDTH + SEG - 1) / SEG;

  logic             adv;
  logic [WIDTH-1:0] a_st [NSTG+1];
  logic [WIDTH-1:0] b_st [NSTG+1];
  logic [WIDTH-1:0] s_st [NSTG+1];
  logic             c_st [NSTG+1];
  logic             v_st [NSTG+1];

  // Subtraction folds into addition: A - B - cin = A + ~B + (1 - cin).
  assign adv          = bus.out_ready | ~v_st[NSTG];
  assign bus.in_ready = adv;
  assign a_st[0]      = bus.a;
  assign b_st[0]      = bus.sub ? ~bus.b : bus.b;
  assign c_st[0]      = bus.cin ^ bus.sub;
  assign s_st[0]      = '0;
  assign v_st[0]      = bus.in_valid;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int SW = (k == NSTG - 1) ? (WIDTH - LO) : SEG;

    logic [SW:0]      slice_sum;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;

    assign slice_sum = {1'b0, a_st[k][LO +: SW]} + {1'b0, b_st[k][LO +: SW]} + {{SW{1'b0}}, c_st[k]};

    always_comb begin
      s_d           = s_st[k];
      s_d[LO +: SW] = slice_sum[SW-1:0];
    end

    // Stage boundary k: slice result, its carry and the delayed operands move together.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        a_q <= a_st[k];
        b_q <= b_st[k];
        s_q <= s_d;
        c_q <= slice_sum[SW];
        v_q <= v_st[k];
      end
    end

    assign a_st[k+1] = a_q;
    assign b_st[k+1] = b_q;
    assign s_st[k+1] = s_q;
    assign c_st[k+1] = c_q;
    assign v_st[k+1] = v_q;
  end

  // Carry into the MSB is recovered from the MSB's own sum bit: a ^ b_eff ^ s.
  assign bus.out_valid = v_st[NSTG];
  assign bus.s         = s_st[NSTG];
  assign bus.cout      = c_st[NSTG];
  assign bus.ovf       = c_st[NSTG] ^ (a_st[NSTG][WIDTH-1] ^ b_st[NSTG][WIDTH-1] ^ s_st[NSTG][WIDTH-1]);
endmodule
